// File: rtl/peripheral_pkg.sv
// peripheral_pkg: shared bus-slot constants, timer register map and mode encoding
package peripheral_pkg;
   localparam logic [23:0] TIMER_ADDR_HIGH = 24'hFFFF_FF;
   localparam int          TIMER_INT_IDX   = 7;
   localparam logic [7:0] TIMER_SYS_LO   = 8'h00;
   localparam logic [7:0] TIMER_SYS_HI   = 8'h04;
   localparam logic [7:0] TIMER_DELAY_LO = 8'h08;
   localparam logic [7:0] TIMER_DELAY_HI = 8'h0C;
   localparam logic [7:0] TIMER_MODE     = 8'h10;
   localparam logic [7:0] TIMER_REPEAT   = 8'h14;
   localparam logic [7:0] TIMER_RST      = 8'h24;
   typedef enum logic [1:0] {TIMER_OFF = 2'd0, TIMER_NTIMES = 2'd1, TIMER_FOREVER = 2'd2} timer_mode_e;
   // A timer may count only with a usable interval and, in NTIMES, firings left.
   function automatic logic timer_armed(logic [1:0] mode, logic [63:0] delay, logic [31:0] rep);
      return delay != 64'd0 && (mode == TIMER_FOREVER || (mode == TIMER_NTIMES && rep != 32'd0));
   endfunction
endpackage

// File: rtl/timer_sb_ctrl.sv
// timer_sb_ctrl: system-bus timer slot with 64-bit cycle counter and interval interrupt
module timer_sb_ctrl
   import peripheral_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        write_enable_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] write_data_i,
   output logic [31:0] read_data_o,
   output logic        ready_o,
   output logic        irq_req_o,
   input  logic        irq_ret_i
);
   typedef enum logic {IDLE, RUN} state_e;
   state_e      state;
   logic [63:0] sys_cnt, delay, cnt, delay_n;
   logic [31:0] hi_snap, rep, rep_n, rd_val;
   logic [1:0]  mode, mode_n;
   logic [7:0]  a;
   logic        wr, rd, soft_rst, cfg_wr, fire;
   assign a        = addr_i[7:0];
   assign wr       = req_i && write_enable_i;
   assign rd       = req_i && !write_enable_i;
   assign soft_rst = wr && a == TIMER_RST && write_data_i == 32'd1;
   assign cfg_wr   = wr && (a == TIMER_DELAY_LO || a == TIMER_DELAY_HI || a == TIMER_MODE || a == TIMER_REPEAT);
   assign delay_n  = {wr && a == TIMER_DELAY_HI ? write_data_i : delay[63:32],
                      wr && a == TIMER_DELAY_LO ? write_data_i : delay[31:0]};
   assign mode_n   = wr && a == TIMER_MODE ? write_data_i[1:0] : mode;
   assign rep_n    = wr && a == TIMER_REPEAT ? write_data_i : rep;
   assign fire     = state == RUN && !cfg_wr && cnt == delay - 64'd1;
   assign ready_o  = 1'b1;
   always_comb begin
      rd_val = 32'd0;
      case (a)
         TIMER_SYS_LO:   rd_val = sys_cnt[31:0];
         TIMER_SYS_HI:   rd_val = hi_snap;
         TIMER_DELAY_LO: rd_val = delay[31:0];
         TIMER_DELAY_HI: rd_val = delay[63:32];
         TIMER_MODE:     rd_val = {30'd0, mode};
         TIMER_REPEAT:   rd_val = rep;
         default:        rd_val = 32'd0;
      endcase
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sys_cnt     <= '0;
         hi_snap     <= '0;
         delay       <= '0;
         rep         <= '0;
         mode        <= '0;
         cnt         <= '0;
         state       <= IDLE;
         irq_req_o   <= 1'b0;
         read_data_o <= '0;
      end else if (soft_rst) begin
         sys_cnt     <= '0;
         hi_snap     <= '0;
         delay       <= '0;
         rep         <= '0;
         mode        <= '0;
         cnt         <= '0;
         state       <= IDLE;
         irq_req_o   <= 1'b0;
         read_data_o <= '0;
      end else begin
         sys_cnt   <= sys_cnt + 64'd1;
         irq_req_o <= fire || (irq_req_o && !irq_ret_i);
         delay     <= delay_n;
         rep       <= rep_n;
         mode      <= mode_n;
         if (rd) read_data_o <= rd_val;
         if (rd && a == TIMER_SYS_LO) hi_snap <= sys_cnt[63:32];
         // A config write restarts the interval; a running timer keeps going only if still armed.
         if (cfg_wr) begin
            cnt   <= '0;
            state <= state == RUN && timer_armed(mode_n, delay_n, rep_n) ? RUN : IDLE;
         end else if (state == IDLE) begin
            state <= timer_armed(mode, delay, rep) ? RUN : IDLE;
         end else if (fire) begin
            cnt <= '0;
            if (mode == TIMER_NTIMES) begin
               rep <= rep - 32'd1;
               if (rep == 32'd1) begin
                  mode  <= TIMER_OFF;
                  state <= IDLE;
               end
            end
         end else begin
            cnt <= cnt + 64'd1;
         end
      end
   end
endmodule
